// File: rtl/pdof_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pdof_pkg
// Description : Shared constants and types for the pdof sequencer: dMv width,
//               subblock count, reference-row count, dMv type and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package pdof_pkg;

    localparam int DMV_W   = 11;  // signed width of one dMv component
    localparam int NUM_SB  = 16;  // dMv x/y pairs per 4x4 job
    localparam int ROW_NUM = 6;   // 4 rows plus one pad row each side
    localparam int CNT_W   = 3;   // wide enough to hold 0..ROW_NUM

    typedef logic signed [DMV_W-1:0] dmv_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT    = 3'd2,
        COMPUTE = 3'd3,
        EXPORT  = 3'd4
    } pdof_state_e;

endpackage
`default_nettype wire

// File: rtl/pdof_sched.sv
`default_nettype none
// ============================================================================
// Module      : pdof_sched
// Description : Per-subblock sequencer for the pdof refinement datapath.
//               Accepts one job, fetches the reference rows of the gradient
//               window, waits the refinement latency, pulses the export strobe
//               and hands the result downstream over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module pdof_sched
    import pdof_pkg::*;
#(
    parameter int PROF_LAT = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        job_valid,
    output logic                        job_ready,
    input  logic                        job_prof_en,
    input  logic [2*NUM_SB*DMV_W-1:0]   job_dmv,
    output logic                        ref_req,
    output logic [2:0]                  ref_row,
    input  logic                        ref_gnt,
    input  logic                        ref_rvalid,
    output logic                        pdof_en,
    output logic                        pdof_enab_prof,
    output logic                        pdof_export,
    output dmv_t                        pdof_dmv_x [NUM_SB],
    output dmv_t                        pdof_dmv_y [NUM_SB],
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        err_extra_beat
);

    localparam int               LAT_W      = (PROF_LAT > 1) ? $clog2(PROF_LAT) : 1;
    localparam logic [CNT_W-1:0] C_LAST_ROW = CNT_W'(ROW_NUM - 1);
    localparam logic [CNT_W-1:0] C_ROWS     = CNT_W'(ROW_NUM);
    localparam logic [LAT_W-1:0] C_LAT_LAST = LAT_W'(PROF_LAT - 1);

    pdof_state_e      r_state;
    pdof_state_e      w_next_state;
    logic [CNT_W-1:0] r_req_cnt;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [LAT_W-1:0] r_lat_cnt;
    logic             r_exported;   // export strobe already issued for this job
    logic             r_prof_en;
    logic             r_err;
    logic             r_rst_done;   // keeps job_ready low while reset is applied
    logic             w_accept;
    logic             w_beat_take;
    logic             w_beats_done;

    // A beat only counts while the job is still collecting rows; anything else is surplus
    assign w_beat_take  = ref_rvalid && ((r_state == FETCH) || (r_state == WAIT))
                          && (r_beat_cnt != C_ROWS);
    // Include the beat arriving this cycle so the no-stall path needs no extra WAIT cycle
    assign w_beats_done = ((r_beat_cnt + CNT_W'(w_beat_take)) == C_ROWS);
    assign w_accept     = job_valid && job_ready;

    assign job_ready      = (r_state == IDLE) && r_rst_done && !flush;
    assign ref_req        = (r_state == FETCH);
    assign ref_row        = ref_req ? r_req_cnt : '0;
    assign busy           = (r_state != IDLE);
    assign pdof_en        = busy;
    assign pdof_enab_prof = r_prof_en;
    assign pdof_export    = (r_state == EXPORT) && !r_exported;
    assign out_valid      = (r_state == EXPORT) && r_exported;
    assign err_extra_beat = r_err;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                if (ref_gnt && (r_req_cnt == C_LAST_ROW)) begin
                    if (!w_beats_done) begin
                        w_next_state = WAIT;
                    end else begin
                        w_next_state = r_prof_en ? COMPUTE : EXPORT;
                    end
                end
            end
            WAIT: begin
                if (w_beats_done) begin
                    w_next_state = r_prof_en ? COMPUTE : EXPORT;
                end
            end
            COMPUTE: begin
                if (r_lat_cnt == C_LAT_LAST) begin
                    w_next_state = EXPORT;
                end
            end
            EXPORT: begin
                if (r_exported && out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (flush) begin
            w_next_state = IDLE;
        end
    end

    // Row request, beat and latency counters plus export-issued flag; all clear in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_cnt  <= '0;
            r_beat_cnt <= '0;
            r_lat_cnt  <= '0;
            r_exported <= 1'b0;
        end else if (flush || (r_state == IDLE)) begin
            r_req_cnt  <= '0;
            r_beat_cnt <= '0;
            r_lat_cnt  <= '0;
            r_exported <= 1'b0;
        end else begin
            if (ref_req && ref_gnt) begin
                r_req_cnt <= r_req_cnt + CNT_W'(1);
            end
            if (w_beat_take) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
            r_lat_cnt  <= (r_state == COMPUTE) ? (r_lat_cnt + LAT_W'(1)) : '0;
            r_exported <= (r_state == EXPORT);
        end
    end

    // Job-level flags: prof enable captured at accept, sticky surplus-beat error, reset-done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prof_en  <= 1'b0;
            r_err      <= 1'b0;
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_accept) begin
                r_prof_en <= job_prof_en;
            end
            if (ref_rvalid && !w_beat_take) begin
                r_err <= 1'b1;
            end
        end
    end

    // dMv bank: loaded only on job accept so pdof sees stable vectors for the whole job
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SB; i++) begin
                pdof_dmv_x[i] <= '0;
                pdof_dmv_y[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < NUM_SB; i++) begin
                pdof_dmv_x[i] <= dmv_t'(job_dmv[(2*i)*DMV_W +: DMV_W]);
                pdof_dmv_y[i] <= dmv_t'(job_dmv[(2*i+1)*DMV_W +: DMV_W]);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pdof_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdof_sched
// Description : Self-checking bench for pdof_sched. A job-level reference
//               model predicts every output each cycle from counts of granted
//               rows, returned beats and the export time they imply.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdof_sched;
    import pdof_pkg::*;

    localparam int PROF_LAT = 3;
    localparam int DW       = 2*NUM_SB*DMV_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush = 1'b0;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic          job_prof_en = 1'b0;
    logic [DW-1:0] job_dmv = '0;
    logic          ref_req;
    logic [2:0]    ref_row;
    logic          ref_gnt = 1'b0;
    logic          ref_rvalid = 1'b0;
    logic          pdof_en;
    logic          pdof_enab_prof;
    logic          pdof_export;
    dmv_t          pdof_dmv_x [NUM_SB];
    dmv_t          pdof_dmv_y [NUM_SB];
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          err_extra_beat;

    pdof_sched #(.PROF_LAT(PROF_LAT)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_prof_en    (job_prof_en),
        .job_dmv        (job_dmv),
        .ref_req        (ref_req),
        .ref_row        (ref_row),
        .ref_gnt        (ref_gnt),
        .ref_rvalid     (ref_rvalid),
        .pdof_en        (pdof_en),
        .pdof_enab_prof (pdof_enab_prof),
        .pdof_export    (pdof_export),
        .pdof_dmv_x     (pdof_dmv_x),
        .pdof_dmv_y     (pdof_dmv_y),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .err_extra_beat (err_extra_beat)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: job-level bookkeeping
    bit m_busy, m_prof, m_err, m_rstdone;
    int m_rows, m_beats, m_exp_cyc, m_acc_cyc;
    int m_dx [NUM_SB];
    int m_dy [NUM_SB];
    int n_export, last_export;

    task automatic check(input string tag, input logic signed [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rand_dmv();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < 2*NUM_SB; i++) v[i*DMV_W +: DMV_W] = DMV_W'($urandom);
        return v;
    endfunction

    function automatic logic [DW-1:0] set_pair(input logic [DW-1:0] v, input int i,
                                               input int x, input int y);
        logic [DW-1:0] r;
        r = v;
        r[(2*i)*DMV_W +: DMV_W]   = DMV_W'(x);
        r[(2*i+1)*DMV_W +: DMV_W] = DMV_W'(y);
        return r;
    endfunction

    // One clock: entered at posedge+1 with inputs driven, returns at the next posedge+1
    task automatic tick();
        bit e_ready, e_req, e_export, e_valid, was_busy;
        int e_row, idx;
        #1;
        was_busy = m_busy;
        e_ready  = m_rstdone && !m_busy && !flush;
        e_req    = m_busy && (m_rows < ROW_NUM);
        e_row    = e_req ? m_rows : 0;
        e_export = m_busy && (cyc == m_exp_cyc);
        e_valid  = m_busy && (m_exp_cyc >= 0) && (cyc > m_exp_cyc);
        check("job_ready", job_ready, int'(e_ready));
        check("ref_req", ref_req, int'(e_req));
        check("ref_row", ref_row, e_row);
        check("busy", busy, int'(m_busy));
        check("pdof_en", pdof_en, int'(m_busy));
        check("enab_prof", pdof_enab_prof, int'(m_prof));
        check("pdof_export", pdof_export, int'(e_export));
        check("out_valid", out_valid, int'(e_valid));
        check("err_extra_beat", err_extra_beat, int'(m_err));
        idx = cyc % NUM_SB;
        check("dmv_x", pdof_dmv_x[idx], m_dx[idx]);
        check("dmv_y", pdof_dmv_y[idx], m_dy[idx]);
        if (e_export) begin
            for (int i = 0; i < NUM_SB; i++) begin
                check("exp_dmv_x", pdof_dmv_x[i], m_dx[i]);
                check("exp_dmv_y", pdof_dmv_y[i], m_dy[i]);
            end
        end
        if (pdof_export === 1'b1) begin
            n_export++;
            last_export = cyc;
        end
        // model update for the coming edge
        if (ref_rvalid) begin
            if (m_busy && m_beats < ROW_NUM) m_beats++;
            else m_err = 1'b1;
        end
        if (e_req && ref_gnt) m_rows++;
        if (m_busy && m_rows == ROW_NUM && m_beats == ROW_NUM && m_exp_cyc < 0)
            m_exp_cyc = cyc + 1 + (m_prof ? PROF_LAT : 0);
        if (e_valid && out_ready) m_busy = 1'b0;
        if (flush) m_busy = 1'b0;
        if (!was_busy && job_valid && e_ready) begin
            m_busy    = 1'b1;
            m_prof    = job_prof_en;
            m_rows    = 0;
            m_beats   = 0;
            m_exp_cyc = -1;
            m_acc_cyc = cyc;
            for (int i = 0; i < NUM_SB; i++) begin
                m_dx[i] = $signed(job_dmv[(2*i)*DMV_W +: DMV_W]);
                m_dy[i] = $signed(job_dmv[(2*i+1)*DMV_W +: DMV_W]);
            end
        end
        m_rstdone = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Asynchronous reset: outputs must drop immediately, then release off the edge
    task automatic apply_reset();
        job_valid = 0; flush = 0; ref_gnt = 0; ref_rvalid = 0; out_ready = 0;
        rst_n = 1'b0;
        #1;
        check("rst_job_ready", job_ready, 0);
        check("rst_ref_req", ref_req, 0);
        check("rst_ref_row", ref_row, 0);
        check("rst_pdof_en", pdof_en, 0);
        check("rst_enab_prof", pdof_enab_prof, 0);
        check("rst_export", pdof_export, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_extra_beat, 0);
        for (int i = 0; i < NUM_SB; i++) begin
            check("rst_dmv_x", pdof_dmv_x[i], 0);
            check("rst_dmv_y", pdof_dmv_y[i], 0);
            m_dx[i] = 0;
            m_dy[i] = 0;
        end
        m_busy = 0; m_prof = 0; m_err = 0; m_rstdone = 0;
        m_rows = 0; m_beats = 0; m_exp_cyc = -1;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst_n = 1'b1;
    endtask

    // Directed job: offsets are cycles after the accept cycle
    task automatic run_job(input bit prof, input logic [DW-1:0] dmv,
                           input int stall_row, input int stall_len, input int ready_hold,
                           input int flush_off, input int extra_off,
                           output int delta, output int pulses);
        int  stalled;
        int  off;
        bit  req_now;
        stalled = 0;
        flush = 0; ref_gnt = 0; ref_rvalid = 0; out_ready = 0;
        job_valid = 1; job_prof_en = prof; job_dmv = dmv;
        tick();
        job_valid = 0;
        job_dmv   = rand_dmv();
        check("accept_busy", busy, 1);
        n_export = 0;
        last_export = -1;
        for (int k = 0; k < 80 && m_busy; k++) begin
            off     = cyc - m_acc_cyc;
            req_now = (m_rows < ROW_NUM);
            ref_gnt = 1'b1;
            if (req_now && m_rows == stall_row && stalled < stall_len) begin
                ref_gnt = 1'b0;
                stalled++;
            end
            ref_rvalid = ((m_rows + ((req_now && ref_gnt) ? 1 : 0)) > m_beats) || (off == extra_off);
            out_ready  = (m_exp_cyc >= 0 && cyc > m_exp_cyc) ? ((cyc - m_exp_cyc - 1) >= ready_hold) : 1'b0;
            flush      = (off == flush_off);
            tick();
        end
        flush = 0; ref_gnt = 0; ref_rvalid = 0; out_ready = 0;
        check("job_done_busy", busy, 0);
        delta  = (last_export >= 0) ? (last_export - m_acc_cyc) : -1;
        pulses = n_export;
    endtask

    task automatic random_cycle();
        bit req_now;
        int pend;
        job_valid   = $urandom_range(0, 1);
        job_prof_en = $urandom_range(0, 1);
        job_dmv     = rand_dmv();
        flush       = ($urandom_range(0, 49) == 0);
        req_now     = m_busy && (m_rows < ROW_NUM);
        ref_gnt     = ($urandom_range(0, 9) < 7);
        pend        = m_rows + ((req_now && ref_gnt) ? 1 : 0) - m_beats;
        ref_rvalid  = m_busy && (pend > 0) && ($urandom_range(0, 9) < 6);
        out_ready   = $urandom_range(0, 1);
        tick();
    endtask

    initial begin
        int d, p;
        logic [DW-1:0] v;
        #2;
        apply_reset();
        tick();

        // Single PROF job, no stalls, signed extremes in the dMv bank
        v = set_pair(rand_dmv(), 0, -5, 0);
        v = set_pair(v, 15, 7, 1023);
        run_job(1'b1, v, -1, 0, 0, -1, -1, d, p);
        check("t1_export_delay", d, 10);
        check("t1_export_pulses", p, 1);
        check("t1_dmv_x0", pdof_dmv_x[0], -5);
        check("t1_dmv_y15", pdof_dmv_y[15], 1023);
        tick();

        // Bypass: export right after the last beat
        run_job(1'b0, rand_dmv(), -1, 0, 0, -1, -1, d, p);
        check("t2_export_delay", d, 7);
        check("t2_export_pulses", p, 1);

        // Grant stall of 4 cycles on row 2
        run_job(1'b1, rand_dmv(), 2, 4, 0, -1, -1, d, p);
        check("t3_export_delay", d, 14);
        check("t3_export_pulses", p, 1);

        // Downstream back-pressure for 5 cycles
        run_job(1'b1, rand_dmv(), -1, 0, 5, -1, -1, d, p);
        check("t4_export_delay", d, 10);
        check("t4_export_pulses", p, 1);

        // Flush in the second COMPUTE cycle, then a fresh job
        run_job(1'b1, rand_dmv(), -1, 0, 0, 8, -1, d, p);
        check("t5_flush_pulses", p, 0);
        v = set_pair(rand_dmv(), 3, -1024, 511);
        run_job(1'b1, v, -1, 0, 0, -1, -1, d, p);
        check("t5_next_delay", d, 10);
        check("t5_next_dmv_x3", pdof_dmv_x[3], -1024);
        check("t5_next_dmv_y3", pdof_dmv_y[3], 511);

        // Seventh beat during COMPUTE, another surplus beat in IDLE
        run_job(1'b1, rand_dmv(), -1, 0, 0, -1, 8, d, p);
        check("t6_err_set", err_extra_beat, 1);
        ref_rvalid = 1;
        tick();
        ref_rvalid = 0;
        repeat (3) tick();
        check("t6_err_sticky", err_extra_beat, 1);

        // Reset in the middle of FETCH
        job_valid = 1; job_prof_en = 1; job_dmv = rand_dmv();
        tick();
        job_valid = 0; ref_gnt = 1; ref_rvalid = 1;
        tick();
        tick();
        check("t6_fetch_busy", busy, 1);
        apply_reset();
        tick();

        // Randomized traffic with flushes and back-pressure
        for (int n = 0; n < 2000; n++) random_cycle();
        job_valid = 0; flush = 0; ref_gnt = 1; out_ready = 1; ref_rvalid = 0;
        for (int n = 0; n < 60 && m_busy; n++) begin
            ref_rvalid = (m_rows + ((m_rows < ROW_NUM) ? 1 : 0)) > m_beats;
            tick();
        end
        ref_rvalid = 0;
        tick();
        check("drain_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
